// File: rtl/matrix_pkg.sv
// Shared constants, enums and character helpers for the matrix ingest/egress datapath.
package matrix_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int MAX_SIZE   = 5;
   localparam int IDX_W      = 5;

   localparam logic [7:0] ASC_0  = 8'h30;
   localparam logic [7:0] ASC_9  = 8'h39;
   localparam logic [7:0] ASC_SP = 8'h20;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_OVF  = 2'd1,
      ERR_DIM  = 2'd2,
      ERR_CHR  = 2'd3
   } err_code_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GET_M     = 3'd1,
      ST_GET_N     = 3'd2,
      ST_GET_ELEM  = 3'd3,
      ST_ERR_FLUSH = 3'd4
   } parse_state_e;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= ASC_0) && (c <= ASC_9);
   endfunction

   function automatic logic is_delim(input logic [7:0] c);
      return (c == ASC_SP) || (c == ASC_CR) || (c == ASC_LF);
   endfunction

endpackage

// File: rtl/ascii_dec_accum.sv
// Classifies received bytes and accumulates a decimal token; flags overflow on the
// offending digit and signals token end on the delimiter that closes a digit run.
module ascii_dec_accum
   import matrix_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  clear,
   output logic                  digit,
   output logic                  illegal,
   output logic                  tok_end,
   output logic                  ovf,
   output logic [DATA_WIDTH+1:0] acc
);

   localparam int ACC_W   = DATA_WIDTH + 2;
   localparam int EXT_W   = ACC_W + 4;
   localparam int MAX_VAL = (1 << DATA_WIDTH) - 1;

   logic [ACC_W-1:0] acc_r;
   logic             in_tok_r;
   logic             dig_s;
   logic             del_s;
   logic [EXT_W-1:0] acc_x_s;

   assign dig_s   = is_digit(rx_data);
   assign del_s   = is_delim(rx_data);
   assign digit   = dig_s;
   assign illegal = !dig_s && !del_s;
   assign tok_end = rx_valid && del_s && in_tok_r;
   assign ovf     = rx_valid && dig_s && (acc_x_s > EXT_W'(MAX_VAL));
   assign acc     = acc_r;

   // acc*10 + digit as shift-add; the low nibble of an ASCII digit is its value
   always_comb begin
      acc_x_s = ({4'b0000, acc_r} << 3'd3) + ({4'b0000, acc_r} << 3'd1)
              + {{(EXT_W-4){1'b0}}, rx_data[3:0]};
   end

   // Token accumulator: any non-digit byte terminates the current run
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r    <= {ACC_W{1'b0}};
         in_tok_r <= 1'b0;
      end else if (clear) begin
         acc_r    <= {ACC_W{1'b0}};
         in_tok_r <= 1'b0;
      end else if (rx_valid && dig_s) begin
         acc_r    <= acc_x_s[ACC_W-1:0];
         in_tok_r <= 1'b1;
      end else if (rx_valid) begin
         acc_r    <= {ACC_W{1'b0}};
         in_tok_r <= 1'b0;
      end else begin
         acc_r    <= acc_r;
         in_tok_r <= in_tok_r;
      end
   end

endmodule

// File: rtl/uart_to_matrix.sv
// Parses "m n e0 .. e(m*n-1)" ASCII decimal text from the UART receiver into a
// row-major element write stream plus matrix dimensions.
module uart_to_matrix
   import matrix_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  wr_en,
   output logic [IDX_W-1:0]      wr_idx,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [2:0]            row_valid,
   output logic [2:0]            col_valid,
   output logic                  frame_done,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic                  busy
);

   localparam int ACC_W = DATA_WIDTH + 2;
   localparam int TOT_W = IDX_W + 1;

   parse_state_e state_r, state_nx;
   err_code_e    err_nx_s;

   logic                  digit_s, illegal_s, tok_end_s, ovf_s, clear_s;
   logic [ACC_W-1:0]      acc_s;
   logic                  dim_ok_s, last_s;
   logic                  err_set_s, acc_m_s, acc_n_s, wr_s, done_s;
   logic [2:0]            m_r;
   logic [TOT_W-1:0]      total_r;
   logic [IDX_W-1:0]      cnt_r;
   logic                  wr_en_r, frame_done_r, err_r, busy_r;
   logic [IDX_W-1:0]      wr_idx_r;
   logic [DATA_WIDTH-1:0] wr_data_r;
   logic [2:0]            row_r, col_r;
   logic [1:0]            err_code_r;

   ascii_dec_accum u_accum (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .clear    (clear_s),
      .digit    (digit_s),
      .illegal  (illegal_s),
      .tok_end  (tok_end_s),
      .ovf      (ovf_s),
      .acc      (acc_s)
   );

   assign dim_ok_s = (acc_s >= ACC_W'(1)) && (acc_s <= ACC_W'(MAX_SIZE));
   assign last_s   = ({1'b0, cnt_r} == (total_r - TOT_W'(1)));
   assign clear_s  = err_set_s || (state_r == ST_ERR_FLUSH);

   // Next state and per-byte event strobes; an error on an LF needs no flush
   always_comb begin
      state_nx  = state_r;
      err_set_s = 1'b0;
      err_nx_s  = ERR_NONE;
      acc_m_s   = 1'b0;
      acc_n_s   = 1'b0;
      wr_s      = 1'b0;
      done_s    = 1'b0;
      if (state_r == ST_ERR_FLUSH) begin
         if (rx_valid && (rx_data == ASC_LF)) state_nx = ST_IDLE;
         else                                 state_nx = state_r;
      end else if (rx_valid && illegal_s) begin
         err_set_s = 1'b1;
         err_nx_s  = ERR_CHR;
         state_nx  = ST_ERR_FLUSH;
      end else if (ovf_s) begin
         err_set_s = 1'b1;
         err_nx_s  = ERR_OVF;
         state_nx  = ST_ERR_FLUSH;
      end else if (tok_end_s) begin
         case (state_r)
            ST_GET_M, ST_GET_N: begin
               if (dim_ok_s) begin
                  acc_m_s  = (state_r == ST_GET_M);
                  acc_n_s  = (state_r == ST_GET_N);
                  state_nx = (state_r == ST_GET_M) ? ST_GET_N : ST_GET_ELEM;
               end else begin
                  err_set_s = 1'b1;
                  err_nx_s  = ERR_DIM;
                  state_nx  = (rx_data == ASC_LF) ? ST_IDLE : ST_ERR_FLUSH;
               end
            end
            ST_GET_ELEM: begin
               wr_s = 1'b1;
               if (last_s) begin
                  done_s   = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = state_r;
               end
            end
            default: state_nx = state_r;
         endcase
      end else if (rx_valid && digit_s && (state_r == ST_IDLE)) begin
         state_nx = ST_GET_M;
      end else begin
         state_nx = state_r;
      end
   end

   // State, dimension/count bookkeeping and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         m_r          <= 3'd0;
         total_r      <= {TOT_W{1'b0}};
         cnt_r        <= {IDX_W{1'b0}};
         wr_en_r      <= 1'b0;
         wr_idx_r     <= {IDX_W{1'b0}};
         wr_data_r    <= {DATA_WIDTH{1'b0}};
         row_r        <= 3'd0;
         col_r        <= 3'd0;
         frame_done_r <= 1'b0;
         err_r        <= 1'b0;
         err_code_r   <= 2'd0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_nx;
         wr_en_r      <= wr_s;
         frame_done_r <= done_s;
         err_r        <= err_set_s;
         busy_r       <= (state_nx != ST_IDLE);
         if (err_set_s) err_code_r <= err_nx_s;
         if (acc_m_s)   m_r <= acc_s[2:0];
         if (acc_n_s) begin
            row_r   <= m_r;
            col_r   <= acc_s[2:0];
            total_r <= TOT_W'(m_r) * TOT_W'(acc_s[2:0]);
            cnt_r   <= {IDX_W{1'b0}};
         end else if (wr_s) begin
            cnt_r   <= cnt_r + IDX_W'(1);
         end
         if (wr_s) begin
            wr_idx_r  <= cnt_r;
            wr_data_r <= acc_s[DATA_WIDTH-1:0];
         end
      end
   end

   assign wr_en      = wr_en_r;
   assign wr_idx     = wr_idx_r;
   assign wr_data    = wr_data_r;
   assign row_valid  = row_r;
   assign col_valid  = col_r;
   assign frame_done = frame_done_r;
   assign err        = err_r;
   assign err_code   = err_code_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_uart_to_matrix.sv
// Directed bench for uart_to_matrix: sends ASCII frames and checks the write stream,
// dimensions, error reporting and reset behaviour against hand-computed values.
module tb_uart_to_matrix;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       wr_en;
   logic [4:0] wr_idx;
   logic [7:0] wr_data;
   logic [2:0] row_valid, col_valid;
   logic       frame_done, err, busy;
   logic [1:0] err_code;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_cons, err_cyc, wr_cyc, n_done, n_long;
   int w_idx[$], w_dat[$], w_done[$], e_code[$];
   int exp_q[$];
   logic err_q = 1'b0, wr_q = 1'b0, done_q = 1'b0;

   uart_to_matrix dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .row_valid  (row_valid),
      .col_valid  (col_valid),
      .frame_done (frame_done),
      .err        (err),
      .err_code   (err_code),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Cycle counter used to timestamp consumed bytes and observed pulses
   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (wr_en) begin
         w_idx.push_back(int'(wr_idx));
         w_dat.push_back(int'(wr_data));
         w_done.push_back(int'(frame_done));
         wr_cyc = cyc;
      end
      if (frame_done) n_done++;
      if (err) begin
         e_code.push_back(int'(err_code));
         err_cyc = cyc;
      end
      if ((err && err_q) || (wr_en && wr_q) || (frame_done && done_q)) n_long++;
      err_q  = err;
      wr_q   = wr_en;
      done_q = frame_done;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Called and returns at posedge+1
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_str(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         rx_data  = s[i];
         rx_valid = 1'b1;
         @(posedge clk);
         #1;
         last_cons = cyc;
         rx_valid  = 1'b0;
         tick(gap);
      end
   endtask

   task automatic clear_log();
      w_idx.delete();
      w_dat.delete();
      w_done.delete();
      e_code.delete();
      n_done = 0;
   endtask

   task automatic check_frame(input string tag, input int exp_d[$], input int exp_done);
      check_eq({tag, "_nwr"}, w_dat.size(), exp_d.size());
      for (int i = 0; i < exp_d.size(); i++) begin
         if (i < w_dat.size()) begin
            check_eq({tag, "_idx"}, w_idx[i], i);
            check_eq({tag, "_dat"}, w_dat[i], exp_d[i]);
            check_eq({tag, "_done"}, w_done[i], (i == exp_d.size() - 1) ? exp_done : 0);
         end
      end
      check_eq({tag, "_ndone"}, n_done, exp_done);
   endtask

   task automatic check_err(input string tag, input int n_exp, input int code);
      check_eq({tag, "_nerr"}, e_code.size(), n_exp);
      if (e_code.size() > 0) check_eq({tag, "_code"}, e_code[0], code);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_wr_en"}, wr_en, 0);
      check_eq({tag, "_wr_idx"}, wr_idx, 0);
      check_eq({tag, "_wr_data"}, wr_data, 0);
      check_eq({tag, "_row"}, row_valid, 0);
      check_eq({tag, "_col"}, col_valid, 0);
      check_eq({tag, "_done"}, frame_done, 0);
      check_eq({tag, "_err"}, err, 0);
      check_eq({tag, "_code"}, err_code, 0);
      check_eq({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      n_long   = 0;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tick(3);
      check_all_zero("reset");
      rst = 1'b0;
      tick(2);

      // Basic 2x3 frame
      clear_log();
      send_str("2", 2);
      check_eq("t1_busy_m", busy, 1);
      send_str(" 3 1 2 3 4 5 6\n", 2);
      check_eq("t1_wr_lat", wr_cyc, last_cons);
      tick(2);
      check_eq("t1_row", row_valid, 2);
      check_eq("t1_col", col_valid, 3);
      exp_q = '{1, 2, 3, 4, 5, 6};
      check_frame("t1", exp_q, 1);
      check_err("t1", 0, 0);
      check_eq("t1_busy_end", busy, 0);

      // Leading/repeated delimiters, max value, back-to-back bytes
      clear_log();
      send_str("  1  1\r\n255 ", 0);
      tick(2);
      exp_q = '{255};
      check_frame("t2", exp_q, 1);
      check_eq("t2_row", row_valid, 1);
      check_eq("t2_col", col_valid, 1);
      check_err("t2", 0, 0);

      // Overflow on the digit that exceeds 255
      clear_log();
      send_str("1 1 25", 2);
      send_str("6", 0);
      tick(1);
      check_eq("t3_err_lat", err_cyc, last_cons);
      send_str(" 7\n", 2);
      tick(2);
      check_err("t3", 1, 1);
      exp_q = '{};
      check_frame("t3", exp_q, 0);
      check_eq("t3_busy", busy, 0);
      clear_log();
      send_str("1 1 9 ", 2);
      tick(2);
      exp_q = '{9};
      check_frame("t3b", exp_q, 1);

      // Illegal character mid-frame; next frame starts from index 0
      clear_log();
      send_str("2 2 1 x 3\n", 2);
      tick(2);
      exp_q = '{1};
      check_frame("t5", exp_q, 0);
      check_err("t5", 1, 3);
      check_eq("t5_busy", busy, 0);
      clear_log();
      send_str("1 2 4 5 ", 2);
      tick(2);
      exp_q = '{4, 5};
      check_frame("t5b", exp_q, 1);
      check_eq("t5b_row", row_valid, 1);
      check_eq("t5b_col", col_valid, 2);

      // Bad dimensions keep the previously published m/n
      clear_log();
      send_str("6 ", 2);
      check_eq("t4_busy_flush", busy, 1);
      send_str("2 1\n", 2);
      tick(2);
      check_err("t4a", 1, 2);
      check_eq("t4a_busy", busy, 0);
      clear_log();
      send_str("0 3 1\n", 2);
      tick(2);
      check_err("t4b", 1, 2);
      clear_log();
      send_str("2 0 1\n", 2);
      tick(2);
      check_err("t4c", 1, 2);
      check_eq("t4_row", row_valid, 1);
      check_eq("t4_col", col_valid, 2);
      check_eq("t4_busy", busy, 0);
      exp_q = '{};
      check_frame("t4", exp_q, 0);

      // Reset mid-frame with a byte arriving in the same cycle
      clear_log();
      send_str("2 2 7 8 ", 2);
      rst      = 1'b1;
      rx_data  = 8'h39;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      rx_valid = 1'b0;
      check_all_zero("t6_rst");
      tick(2);
      clear_log();
      send_str("2 2 1 2 3 4 ", 2);
      tick(2);
      exp_q = '{1, 2, 3, 4};
      check_frame("t6", exp_q, 1);
      check_eq("t6_row", row_valid, 2);
      check_eq("t6_col", col_valid, 2);
      check_err("t6", 0, 0);

      check_eq("pulse_width", n_long, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_to_matrix.md
Name: uart_to_matrix

Overview:
- Upstream ingest stage of the matrix datapath. It consumes received UART bytes and parses ASCII decimal text of the form "m n e0 e1 … e(m*n-1)".
- It emits a row-major element write stream plus dimensions into the multi-matrix storage.
- It is the input-side counterpart of the matrix-to-UART hex dump path: storage is filled by this block, then burst-read and transmitted by the output path.

Parameters:
- DATA_WIDTH, 8, element width; the legal element range is 0..2^DATA_WIDTH-1.
- MAX_SIZE, 5, maximum rows and columns per matrix.
- IDX_W, 5, linear write index width; must satisfy 2^IDX_W >= MAX_SIZE*MAX_SIZE.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- rx_data  in  8  byte from the UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- wr_en  out  1  one-cycle element write strobe to storage
- wr_idx  out  IDX_W  linear element index, row*n+col
- wr_data  out  DATA_WIDTH  element value
- row_valid  out  3  parsed m, held until the next frame's m is accepted
- col_valid  out  3  parsed n, held likewise
- frame_done  out  1  one-cycle pulse, all m*n elements written
- err  out  1  one-cycle pulse on parse error
- err_code  out  2  1=value overflow, 2=bad dimension, 3=illegal char; held until next err
- busy  out  1  high from the first digit of m until frame_done or return to IDLE

Behaviour:
- Reset (synchronous, rst=1 at posedge; wins over rx_valid):
  - state=IDLE, accumulator=0, element count=0.
  - All outputs 0: wr_en, wr_idx, wr_data, row_valid, col_valid, frame_done, err, err_code, busy.
- Character classes:
  - digit '0'..'9' (0x30-0x39)
  - delimiter: space 0x20, CR 0x0D, LF 0x0A
  - everything else is illegal.
- Accumulator is DATA_WIDTH+2 bits wide; each digit does acc <= acc*10 + digit.
- Overflow: if acc exceeds 2^DATA_WIDTH-1 → err code 1. This is detected on the digit that overflows, not at the delimiter.
- A token is a maximal digit run. The token ends on a delimiter; consecutive delimiters produce no tokens.
- States:
  - IDLE: delimiters ignored. A digit loads acc and goes to GET_M with busy=1. An illegal char → ERR_FLUSH.
  - GET_M: on token end, require 1<=acc<=MAX_SIZE, else err code 2. Store m, clear acc, go to GET_N. It waits through leading delimiters for the next digit.
  - GET_N: same check as GET_M. Store n, cnt=0, go to GET_ELEM. row_valid/col_valid update together when n is accepted, not when m is.
  - GET_ELEM: on token end, the next cycle gives wr_en=1, wr_idx=cnt, wr_data=acc[DATA_WIDTH-1:0], then cnt++.
    - When cnt reaches m*n-1, frame_done pulses in the same cycle as that wr_en, busy drops that cycle, and the state returns to IDLE.
  - ERR_FLUSH: err=1 and err_code are set the cycle after the offending byte. All bytes are discarded until an LF, which returns to IDLE (the LF is consumed). Elements already written stay in storage; frame_done is not pulsed.
- Latency: exactly 1 clk from the delimiter's rx_valid to wr_en or err. Output pulses never exceed one cycle.
- An illegal char in any state → err code 3 → ERR_FLUSH.
- A new frame starts only after IDLE is reached. Bytes after the last element's delimiter belong to the next frame.
- m*n is computed once at n acceptance and registered as IDX_W+1 bits; there is no multiply in the element path.
- rx_valid is never asserted on consecutive cycles at UART rates, but RTL must still be correct if it is.

Decomposition:
- Shared package matrix_pkg:
  - DATA_WIDTH, MAX_SIZE, IDX_W
  - ASCII constants: ASC_0, ASC_9, ASC_SP, ASC_CR, ASC_LF
  - err code enum: ERR_OVF, ERR_DIM, ERR_CHR
  - parser state enum
- One natural sub-module: ascii_dec_accum. It does character classification, acc*10+digit with overflow flag, and token-end detection. The FSM stays in uart_to_matrix.

Test Plan:
- Send "2 3 1 2 3 4 5 6\n" → row_valid=2, col_valid=3; six wr_en with idx 0..5 and data 1..6; frame_done coincident with idx 5; err never.
- Send "  1  1\r\n255 " → single write, idx 0, data 0xFF; frame_done; leading and repeated delimiters ignored.
- Send "1 1 256 7\n" → err=1, code 1, on the '6' byte +1 clk; no wr_en; next frame "1 1 9 " writes data 9.
- Send "6 2 …\n" then "0 3 …\n" → err code 2 for each; row_valid/col_valid keep prior values; busy returns low after the LF.
- Send "2 2 1 x 3\n" → one write (idx 0, data 1), then err code 3; no frame_done; next valid frame starts at idx 0.
- Assert rst while in GET_ELEM after 2 of 4 elements, with rx_valid high in the same cycle → all outputs 0 next cycle, state IDLE; a following full frame parses correctly from idx 0.
